ariane_axi_port_arbiter: RTL and testbench
==========================================

# ariane_axi_port_arbiter

Shares one `ariane_axi` master port (`req_t`/`resp_t`, 4-bit ID, 64-bit address and data) between `NumMst` requesters, e.g. icache, dcache and the bypass path. Read and write channels are arbitrated independently, each with its own round-robin pointer. A grant is locked for the full transaction: AR until the last R beat, and AW+W until B. The block sits between the cache subsystem and the SoC AXI crossbar.

## Interface
- `NumMst`, default 2: number of requesters, at least 2. The index width is `$clog2(NumMst)`.
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: asynchronous active-low reset.
- `mst_req_i`  in  `ariane_axi::req_t [NumMst]`: requester-side requests.
- `mst_resp_o`  out  `ariane_axi::resp_t [NumMst]`: requester-side responses.
- `slv_req_o`  out  `ariane_axi::req_t`: shared port toward the crossbar.
- `slv_resp_i`  in  `ariane_axi::resp_t`: shared port responses.

## Operation
- **Read FSM.** States are `R_IDLE`, `R_ADDR` and `R_DATA`.
  - `R_IDLE`: if any `ar_valid` is set, pick the first asserted index searching upward from `rd_ptr` with wrap. Register it as `rd_gnt` and go to `R_ADDR`.
  - `R_ADDR`: drive `slv_req_o.ar` and `ar_valid` from `rd_gnt`. Return `ar_ready` only to `rd_gnt`. On AR handshake go to `R_DATA`.
  - `R_DATA`: route `r_valid` and `r` to `rd_gnt`, and take `r_ready` from `rd_gnt`. On a handshake with `r.last`=1: go to `R_IDLE` and set `rd_ptr` = (`rd_gnt`+1) mod `NumMst`.
- **Write FSM.** States are `W_IDLE`, `W_ADDR`, `W_DATA` and `W_RESP`. Index selection is the same as the read FSM, using `aw_valid` and `wr_ptr`, and registers `wr_gnt`.
  - `W_ADDR`: forward AW. On AW handshake go to `W_DATA`.
  - `W_DATA`: forward W. On a W handshake with `w.last`=1 go to `W_RESP`.
  - `W_RESP`: route `b_valid` and `b` to `wr_gnt`, and take `b_ready` from `wr_gnt`. On B handshake go to `W_IDLE` and set `wr_ptr` = (`wr_gnt`+1) mod `NumMst`.
- **Gating and idle values.**
  - Channels not in their active state drive valid/ready = 0 and payload = 0 on the slave side.
  - Non-granted requesters see `aw_ready`, `w_ready`, `ar_ready`, `b_valid` and `r_valid` = 0 at all times.
- **Outstanding limit.** At most one read and one write are outstanding. The read and write FSMs never block each other.
- **No W before AW.** W is never forwarded before its AW is accepted. The downstream port must accept AW without a preceding W.
- **IDs and atomics.**
  - IDs pass through unchanged; no ID prefixing.
  - `aw.atop[5]`=1 (R-response atomics) is unsupported. A simulation assertion fires; the request is forwarded unchanged.
- **Requester obligations.** Each requester must hold `*_valid` and payload stable until the handshake (AXI rule). A simulation assertion checks this on the granted index.

## Timing
- **Reset (async, `rst_ni`=0).**
  - Both FSMs return to IDLE.
  - `rd_ptr`, `wr_ptr`, `rd_gnt` and `wr_gnt` = 0.
  - Every valid and ready on both sides = 0, and all slave payloads = 0.
  - Reset mid-burst abandons the transaction with no completion, and both FSMs resume in IDLE.
- **Latency.**
  - AR/AW: `*_valid` sampled in IDLE at edge N appears on `slv_req_o` in cycle N+1.
  - AR/AW handshake completes no earlier than cycle N+1.
  - W beats, R beats and B are combinational pass-through: 0 cycles of added latency and no bubbles.
- **Back-to-back.** After the last R (or B) handshake at edge M, the next AR (or AW) appears at M+2: one IDLE cycle, then ADDR.
- **Simultaneous requests.** Lowest index at or above the pointer wins. Example with `NumMst`=2 and both requesting continuously: grants alternate 0,1,0,1.
- **Single requester.** A lone requester wins every arbitration regardless of pointer position. Its grant rate is one transaction per transaction length + 2 cycles.
- **Empty bursts.** `len`=0 means a single beat with `last`=1; it completes R_DATA/W_DATA in one beat.

## Test plan
- **Reset values.** Assert `rst_ni`=0 mid-read burst (beat 2 of 4) → next cycle all valids/readies = 0, FSMs IDLE. After release, a fresh AR from master 1 is forwarded at N+1.
- **Read contention.** Masters 0 and 1 both hold `ar_valid` (addr 0x1000 and 0x2000, `len`=3) → slave sees 0x1000, then 4 R beats to master 0 only, then 0x2000. Master 1 sees `r_valid`=0 throughout the first burst.
- **Write contention and ordering.** Both masters issue 2-beat writes, master 1 raising `w_valid` before `aw_valid` → W is withheld until its AW handshake. B with id 0x3 routes only to the granted master, and the next grant goes to the other master.
- **Read/write concurrency.** Master 0 reads (`len`=7) while master 1 writes (`len`=0) → both progress in parallel. The write B completes while R beats are still flowing, with no stalls on either side.
- **Backpressure.** Slave `r_valid` toggles, or master `r_ready`=0 for 5 cycles → no beat lost or duplicated, and `last` is observed exactly once.
- **Round-robin wrap.** With `NumMst`=3 and all requesting AR continuously → grant order 0,1,2,0,1,2. With only master 2 requesting → master 2 is granted every transaction.

Source files
------------

// File: rtl/ariane_axi_port_arbiter.sv
// rtl/ariane_axi_port_arbiter.sv - shares one ariane_axi master port among NumMst requesters
// Independent round-robin read and write arbiters; each grant is held for the whole transaction.

package ariane_axi;
   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [5:0]  atop;
   } aw_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

module ariane_axi_port_arbiter #(
   parameter int unsigned NumMst = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  ariane_axi::req_t  mst_req_i  [NumMst],
   output ariane_axi::resp_t mst_resp_o [NumMst],
   output ariane_axi::req_t  slv_req_o,
   input  ariane_axi::resp_t slv_resp_i
);
   localparam int unsigned IdxW = $clog2(NumMst);
   typedef logic [IdxW-1:0] idx_t;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

   rd_state_e rd_state_q, rd_state_d;
   wr_state_e wr_state_q, wr_state_d;
   idx_t      rd_ptr_q, rd_ptr_d, rd_gnt_q, rd_gnt_d;
   idx_t      wr_ptr_q, wr_ptr_d, wr_gnt_q, wr_gnt_d;
   logic [NumMst-1:0] ar_req, aw_req;

   // First asserted request at or above ptr, wrapping past NumMst-1.
   function automatic idx_t rr_pick(input logic [NumMst-1:0] req, input idx_t ptr);
      idx_t pick;
      idx_t cand;
      logic found;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < NumMst; k++) begin
         cand = idx_t'((32'(ptr) + k) % NumMst);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic idx_t next_idx(input idx_t i);
      return (32'(i) + 32'd1 >= NumMst) ? '0 : i + idx_t'(1);
   endfunction

   always_comb begin
      rd_state_d = rd_state_q;
      rd_ptr_d   = rd_ptr_q;
      rd_gnt_d   = rd_gnt_q;
      wr_state_d = wr_state_q;
      wr_ptr_d   = wr_ptr_q;
      wr_gnt_d   = wr_gnt_q;
      slv_req_o  = '0;
      for (int unsigned m = 0; m < NumMst; m++) begin
         mst_resp_o[m] = '0;
         ar_req[m]     = mst_req_i[m].ar_valid;
         aw_req[m]     = mst_req_i[m].aw_valid;
      end

      case (rd_state_q)
         R_IDLE: begin
            if (|ar_req) begin
               rd_gnt_d   = rr_pick(ar_req, rd_ptr_q);
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            slv_req_o.ar_valid             = mst_req_i[rd_gnt_q].ar_valid;
            slv_req_o.ar                   = mst_req_i[rd_gnt_q].ar;
            mst_resp_o[rd_gnt_q].ar_ready = slv_resp_i.ar_ready;
            if (mst_req_i[rd_gnt_q].ar_valid && slv_resp_i.ar_ready) rd_state_d = R_DATA;
         end
         R_DATA: begin
            mst_resp_o[rd_gnt_q].r_valid = slv_resp_i.r_valid;
            mst_resp_o[rd_gnt_q].r       = slv_resp_i.r;
            slv_req_o.r_ready            = mst_req_i[rd_gnt_q].r_ready;
            if (slv_resp_i.r_valid && mst_req_i[rd_gnt_q].r_ready && slv_resp_i.r.last) begin
               rd_state_d = R_IDLE;
               rd_ptr_d   = next_idx(rd_gnt_q);
            end
         end
         default: rd_state_d = R_IDLE;
      endcase

      // W is only opened after AW has been accepted, so W never overtakes its address.
      case (wr_state_q)
         W_IDLE: begin
            if (|aw_req) begin
               wr_gnt_d   = rr_pick(aw_req, wr_ptr_q);
               wr_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            slv_req_o.aw_valid             = mst_req_i[wr_gnt_q].aw_valid;
            slv_req_o.aw                   = mst_req_i[wr_gnt_q].aw;
            mst_resp_o[wr_gnt_q].aw_ready = slv_resp_i.aw_ready;
            if (mst_req_i[wr_gnt_q].aw_valid && slv_resp_i.aw_ready) wr_state_d = W_DATA;
         end
         W_DATA: begin
            slv_req_o.w_valid             = mst_req_i[wr_gnt_q].w_valid;
            slv_req_o.w                   = mst_req_i[wr_gnt_q].w;
            mst_resp_o[wr_gnt_q].w_ready = slv_resp_i.w_ready;
            if (mst_req_i[wr_gnt_q].w_valid && slv_resp_i.w_ready && mst_req_i[wr_gnt_q].w.last)
               wr_state_d = W_RESP;
         end
         W_RESP: begin
            mst_resp_o[wr_gnt_q].b_valid = slv_resp_i.b_valid;
            mst_resp_o[wr_gnt_q].b       = slv_resp_i.b;
            slv_req_o.b_ready            = mst_req_i[wr_gnt_q].b_ready;
            if (slv_resp_i.b_valid && mst_req_i[wr_gnt_q].b_ready) begin
               wr_state_d = W_IDLE;
               wr_ptr_d   = next_idx(wr_gnt_q);
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_state_q <= R_IDLE;
         rd_ptr_q   <= '0;
         rd_gnt_q   <= '0;
         wr_state_q <= W_IDLE;
         wr_ptr_q   <= '0;
         wr_gnt_q   <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_gnt_q   <= rd_gnt_d;
         wr_state_q <= wr_state_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_gnt_q   <= wr_gnt_d;
      end
   end

   // Atomics returning read data would need an R path on the write grant; they are not handled.
   atop_r_unsupported: assert property (@(posedge clk_i) disable iff (!rst_ni)
      slv_req_o.aw_valid |-> !slv_req_o.aw.atop[5]);

   ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rd_state_q == R_ADDR && slv_req_o.ar_valid && !slv_resp_i.ar_ready)
      |=> (slv_req_o.ar_valid && $stable(slv_req_o.ar)));

   aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (wr_state_q == W_ADDR && slv_req_o.aw_valid && !slv_resp_i.aw_ready)
      |=> (slv_req_o.aw_valid && $stable(slv_req_o.aw)));

   w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (wr_state_q == W_DATA && slv_req_o.w_valid && !slv_resp_i.w_ready)
      |=> (slv_req_o.w_valid && $stable(slv_req_o.w)));
endmodule

// File: tb/tb_ariane_axi_port_arbiter.sv
// tb/tb_ariane_axi_port_arbiter.sv - scoreboard bench for ariane_axi_port_arbiter (NumMst=3)
// Stimulus pushes expected transfers; an independent monitor pops them on each handshake.

module tb_ariane_axi_port_arbiter;
   import ariane_axi::*;

   localparam int N = 3;

   logic  clk = 1'b0;
   logic  rst_n;
   req_t  mst_req  [N];
   resp_t mst_resp [N];
   req_t  slv_req;
   resp_t slv_resp;

   always #5 clk = ~clk;

   ariane_axi_port_arbiter #(.NumMst(N)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .mst_req_i  (mst_req),
      .mst_resp_o (mst_resp),
      .slv_req_o  (slv_req),
      .slv_resp_i (slv_resp)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          m;
      logic [63:0] data;
      logic        last;
   } rexp_t;

   logic [63:0] exp_ar [$];
   logic [63:0] exp_aw [$];
   logic [64:0] exp_w  [$];
   rexp_t       exp_r  [$];
   int          exp_bm [$];
   logic [3:0]  exp_bid[$];

   int r_beats = 0, r_lasts = 0, r_last_cyc = 0, b_cyc = 0;
   int ar_hs_prev = 0, ar_hs_last = 0;
   bit r_toggle = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      total++;
      bad++;
      $display("FAIL %s: got transfer %0h want none (cycle %0d)", name, act, cyc);
   endtask

   // Monitor: every handshake visible before the next rising edge pops one expectation.
   initial begin
      int    nrv, nbv;
      rexp_t re;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (slv_req.ar_valid && slv_resp.ar_ready) begin
               ar_hs_prev = ar_hs_last;
               ar_hs_last = cyc;
               if (exp_ar.size() == 0) unexpected("ar_unexpected", slv_req.ar.addr);
               else chk("ar_addr", slv_req.ar.addr, exp_ar.pop_front());
            end
            if (slv_req.aw_valid && slv_resp.aw_ready) begin
               if (exp_aw.size() == 0) unexpected("aw_unexpected", slv_req.aw.addr);
               else chk("aw_addr", slv_req.aw.addr, exp_aw.pop_front());
            end
            if (slv_req.w_valid && slv_resp.w_ready) begin
               if (exp_w.size() == 0) unexpected("w_unexpected", slv_req.w.data);
               else chk("w_beat", {63'd0, slv_req.w.last, slv_req.w.data}, {63'd0, exp_w.pop_front()});
            end
            nrv = 0;
            nbv = 0;
            for (int m = 0; m < N; m++) begin
               if (mst_resp[m].r_valid) nrv++;
               if (mst_resp[m].b_valid) nbv++;
               if (mst_resp[m].r_valid && mst_req[m].r_ready) begin
                  r_beats++;
                  if (mst_resp[m].r.last) begin
                     r_lasts++;
                     r_last_cyc = cyc;
                  end
                  if (exp_r.size() == 0) unexpected("r_unexpected", mst_resp[m].r.data);
                  else begin
                     re = exp_r.pop_front();
                     chk("r_master", 64'(m), 64'(re.m));
                     chk("r_data", mst_resp[m].r.data, re.data);
                     chk("r_last", 64'(mst_resp[m].r.last), 64'(re.last));
                  end
               end
               if (mst_resp[m].b_valid && mst_req[m].b_ready) begin
                  b_cyc = cyc;
                  if (exp_bm.size() == 0) unexpected("b_unexpected", 64'(mst_resp[m].b.id));
                  else begin
                     chk("b_master", 64'(m), 64'(exp_bm.pop_front()));
                     chk("b_id", 64'(mst_resp[m].b.id), 64'(exp_bid.pop_front()));
                  end
               end
            end
            if (nrv > 0) chk("r_valid_onehot", 64'(nrv), 64'd1);
            if (nbv > 0) chk("b_valid_onehot", 64'(nbv), 64'd1);
         end
      end
   end

   // Slave model: always ready for AR/AW/W; R data = addr + beat; B after last W.
   bit          ar_hs, r_hs, aw_hs, w_hs, w_last, b_hs, rd_active, b_pend;
   ar_chan_t    ar_c;
   logic [3:0]  wr_id, rd_id;
   logic [63:0] rd_addr;
   logic [7:0]  rd_len, rd_beat;
   initial begin
      slv_resp  = '0;
      rd_active = 1'b0;
      b_pend    = 1'b0;
      forever begin
         @(negedge clk);
         ar_hs  = slv_req.ar_valid && slv_resp.ar_ready;
         ar_c   = slv_req.ar;
         r_hs   = slv_resp.r_valid && slv_req.r_ready;
         aw_hs  = slv_req.aw_valid && slv_resp.aw_ready;
         w_hs   = slv_req.w_valid && slv_resp.w_ready;
         w_last = slv_req.w.last;
         b_hs   = slv_resp.b_valid && slv_req.b_ready;
         if (aw_hs) wr_id = slv_req.aw.id;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rd_active = 1'b0;
            b_pend    = 1'b0;
         end else begin
            if (ar_hs) begin
               rd_active = 1'b1;
               rd_addr   = ar_c.addr;
               rd_len    = ar_c.len;
               rd_id     = ar_c.id;
               rd_beat   = 8'd0;
            end else if (r_hs) begin
               if (rd_beat == rd_len) rd_active = 1'b0;
               else rd_beat++;
            end
            if (b_hs) b_pend = 1'b0;
            if (w_hs && w_last) b_pend = 1'b1;
         end
         slv_resp.ar_ready = 1'b1;
         slv_resp.aw_ready = 1'b1;
         slv_resp.w_ready  = 1'b1;
         slv_resp.r_valid  = rd_active && !(r_toggle && cyc[0]);
         slv_resp.r.id     = rd_id;
         slv_resp.r.data   = rd_addr + 64'(rd_beat);
         slv_resp.r.resp   = 2'b00;
         slv_resp.r.last   = (rd_beat == rd_len);
         slv_resp.b_valid  = b_pend;
         slv_resp.b.id     = wr_id;
         slv_resp.b.resp   = 2'b00;
      end
   end

   task automatic issue_ar(input int m, input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
      int t = 0;
      mst_req[m].ar.addr  = addr;
      mst_req[m].ar.len   = len;
      mst_req[m].ar.id    = id;
      mst_req[m].ar.size  = 3'd3;
      mst_req[m].ar.burst = 2'd1;
      mst_req[m].ar_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (mst_resp[m].ar_ready) break;
         if (++t > 300) begin
            chk("ar_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      mst_req[m].ar_valid = 1'b0;
      mst_req[m].ar       = '0;
   endtask

   task automatic do_write(input int m, input logic [63:0] addr, input logic [3:0] id, input int nb,
                           input logic [63:0] dbase, input int start, input int pre);
      int t = 0;
      repeat (start) @(posedge clk);
      #1;
      mst_req[m].w.data  = dbase;
      mst_req[m].w.strb  = 8'hff;
      mst_req[m].w.last  = (nb == 1);
      mst_req[m].w_valid = (pre > 0);
      for (int i = 0; i < pre; i++) begin
         @(negedge clk);
         chk("w_withheld", 64'(slv_req.w_valid), 64'd0);
      end
      if (pre > 0) begin
         @(posedge clk);
         #1;
      end
      mst_req[m].aw.addr  = addr;
      mst_req[m].aw.id    = id;
      mst_req[m].aw.len   = 8'(nb - 1);
      mst_req[m].aw.size  = 3'd3;
      mst_req[m].aw.burst = 2'd1;
      mst_req[m].aw_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (mst_resp[m].aw_ready) break;
         if (++t > 300) begin
            chk("aw_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      mst_req[m].aw_valid = 1'b0;
      mst_req[m].aw       = '0;
      for (int b = 0; b < nb; b++) begin
         mst_req[m].w.data  = dbase + 64'(b);
         mst_req[m].w.last  = (b == nb - 1);
         mst_req[m].w_valid = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (mst_resp[m].w_ready) break;
            if (++t > 300) begin
               chk("w_timeout", 64'd0, 64'd1);
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      mst_req[m].w_valid = 1'b0;
      mst_req[m].w       = '0;
   endtask

   task automatic push_r(input int m, input logic [63:0] addr, input int beats);
      rexp_t re;
      for (int i = 0; i < beats; i++) begin
         re.m    = m;
         re.data = addr + 64'(i);
         re.last = (i == beats - 1);
         exp_r.push_back(re);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_ar.size() + exp_aw.size() + exp_w.size() + exp_r.size() + exp_bm.size()) != 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      chk("drain_left", 64'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_r.size() + exp_bm.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int rb0, rl0;
      for (int m = 0; m < N; m++) begin
         mst_req[m]         = '0;
         mst_req[m].r_ready = 1'b1;
         mst_req[m].b_ready = 1'b1;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_slv_req", 64'(slv_req == '0), 64'd1);
      for (int m = 0; m < N; m++) chk("reset_mst_resp", 64'(mst_resp[m] == '0), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Round robin over three continuous requesters.
      foreach (exp_ar[i]) exp_ar.delete(i);
      exp_ar = '{64'h100, 64'h200, 64'h300, 64'h110, 64'h210, 64'h310};
      push_r(0, 64'h100, 1); push_r(1, 64'h200, 1); push_r(2, 64'h300, 1);
      push_r(0, 64'h110, 1); push_r(1, 64'h210, 1); push_r(2, 64'h310, 1);
      fork
         begin issue_ar(0, 64'h100, 8'd0, 4'd1); issue_ar(0, 64'h110, 8'd0, 4'd1); end
         begin issue_ar(1, 64'h200, 8'd0, 4'd2); issue_ar(1, 64'h210, 8'd0, 4'd2); end
         begin issue_ar(2, 64'h300, 8'd0, 4'd3); issue_ar(2, 64'h310, 8'd0, 4'd3); end
      join
      drain();

      // Lone requester 2 wins with pointer at 0; one transaction every len+1+2 cycles.
      exp_ar.push_back(64'hA000); exp_ar.push_back(64'hA010);
      push_r(2, 64'hA000, 1); push_r(2, 64'hA010, 1);
      issue_ar(2, 64'hA000, 8'd0, 4'd4);
      issue_ar(2, 64'hA010, 8'd0, 4'd4);
      drain();
      chk("lone_ar_interval", 64'(ar_hs_last - ar_hs_prev), 64'd3);

      // Read contention: master 0 burst completes entirely before master 1.
      exp_ar.push_back(64'h1000); exp_ar.push_back(64'h2000);
      push_r(0, 64'h1000, 4); push_r(1, 64'h2000, 4);
      fork
         issue_ar(0, 64'h1000, 8'd3, 4'd1);
         issue_ar(1, 64'h2000, 8'd3, 4'd2);
      join
      drain();

      // Write contention; master 1 presents W before AW.
      exp_aw.push_back(64'h3000); exp_aw.push_back(64'h4000);
      exp_w.push_back({1'b0, 64'hA0}); exp_w.push_back({1'b1, 64'hA1});
      exp_w.push_back({1'b0, 64'hB0}); exp_w.push_back({1'b1, 64'hB1});
      exp_bm.push_back(0); exp_bid.push_back(4'h3);
      exp_bm.push_back(1); exp_bid.push_back(4'h4);
      fork
         do_write(0, 64'h3000, 4'h3, 2, 64'hA0, 2, 0);
         do_write(1, 64'h4000, 4'h4, 2, 64'hB0, 0, 2);
      join
      drain();

      // Concurrent read (8 beats) and single-beat write.
      exp_ar.push_back(64'h5000);
      push_r(0, 64'h5000, 8);
      exp_aw.push_back(64'h6000);
      exp_w.push_back({1'b1, 64'hC0});
      exp_bm.push_back(1); exp_bid.push_back(4'h3);
      fork
         issue_ar(0, 64'h5000, 8'd7, 4'd1);
         do_write(1, 64'h6000, 4'h3, 1, 64'hC0, 0, 0);
      join
      drain();
      chk("rd_no_bubble", 64'(r_last_cyc - ar_hs_last), 64'd8);
      chk("b_during_r", 64'(b_cyc < r_last_cyc), 64'd1);

      // Backpressure: toggling slave r_valid plus 5 cycles of master r_ready low.
      rb0 = r_beats;
      rl0 = r_lasts;
      r_toggle = 1'b1;
      exp_ar.push_back(64'h7000);
      push_r(0, 64'h7000, 4);
      fork
         issue_ar(0, 64'h7000, 8'd3, 4'd2);
         begin
            repeat (4) @(posedge clk);
            #1 mst_req[0].r_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 mst_req[0].r_ready = 1'b1;
         end
      join
      drain();
      r_toggle = 1'b0;
      chk("bp_beats", 64'(r_beats - rb0), 64'd4);
      chk("bp_lasts", 64'(r_lasts - rl0), 64'd1);

      // Reset during beat 2 of a 4-beat burst.
      rb0 = r_beats;
      exp_ar.push_back(64'h8000);
      push_r(0, 64'h8000, 4);
      issue_ar(0, 64'h8000, 8'd3, 4'd1);
      for (int t = 0; t < 50 && r_beats < rb0 + 2; t++) @(posedge clk);
      #2;
      chk("rst_reached_beat2", 64'(r_beats - rb0), 64'd2);
      rst_n = 1'b0;
      exp_r.delete();
      @(negedge clk);
      chk("rst_mid_slv_req", 64'(slv_req == '0), 64'd1);
      for (int m = 0; m < N; m++) chk("rst_mid_mst_resp", 64'(mst_resp[m] == '0), 64'd1);
      chk("rst_rd_state", 64'(dut.rd_state_q), 64'd0);
      chk("rst_rd_ptr", 64'(dut.rd_ptr_q), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mst_req[1].ar.addr  = 64'h9000;
      mst_req[1].ar.id    = 4'd6;
      mst_req[1].ar_valid = 1'b1;
      exp_ar.push_back(64'h9000);
      push_r(1, 64'h9000, 1);
      @(negedge clk);
      chk("post_rst_ar_N", 64'(slv_req.ar_valid), 64'd0);
      @(negedge clk);
      chk("post_rst_ar_N1", 64'(slv_req.ar_valid), 64'd1);
      @(posedge clk);
      #1;
      mst_req[1].ar_valid = 1'b0;
      mst_req[1].ar       = '0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
